// File: rtl/c1541_track_loader.sv
// Track-level SD transfer sequencer for the 1541 drive model: settles the head, writes back a
// dirty track, then reads the requested one. Define C1541_TRACK40_EN to enable tracks 36-40.
module c1541_track_loader #(
    parameter int SETTLE_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [5:0]  req_track,
    input  logic        mtr,
    input  logic        buff_we,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic        img_size_ok,
    output logic [5:0]  track,
    output logic        busy,
    output logic [31:0] sd_lba,
    output logic [4:0]  sd_blk_cnt,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack
);

`ifdef C1541_TRACK40_EN
    localparam logic [5:0] TMAX = 6'd40;
`else
    localparam logic [5:0] TMAX = 6'd35;
`endif

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WB_REQ,
        WB_ACK,
        RD_REQ,
        RD_ACK
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [5:0]     target;
    logic [5:0]     req_q;
    logic [5:0]     req_clamped;
    logic           mounted;
    logic           dirty;
    logic           pending;
    logic           flush;
    logic           mtr_q;
    logic           idle_busy;

    function automatic logic [5:0] clamp_track(input logic [5:0] t);
        if (t == 6'd0)
            return 6'd1;
        else if (t > TMAX)
            return TMAX;
        else
            return t;
    endfunction

    function automatic logic [31:0] track_lba(input logic [5:0] t);
        logic [31:0] tt;
        tt = 32'(t);
        if (tt <= 32'd17)
            return (tt - 32'd1) * 32'd21;
        else if (tt <= 32'd24)
            return 32'd357 + (tt - 32'd18) * 32'd19;
        else if (tt <= 32'd30)
            return 32'd490 + (tt - 32'd25) * 32'd18;
`ifdef C1541_TRACK40_EN
        else if (tt <= 32'd35)
            return 32'd598 + (tt - 32'd31) * 32'd17;
        else
            return 32'd683 + (tt - 32'd36) * 32'd17;
`else
        else
            return 32'd598 + (tt - 32'd31) * 32'd17;
`endif
    endfunction

    function automatic logic [4:0] track_blk_cnt(input logic [5:0] t);
        if (t <= 6'd17)
            return 5'd20;
        else if (t <= 6'd24)
            return 5'd18;
        else if (t <= 6'd30)
            return 5'd17;
        else
            return 5'd16;
    endfunction

    always_comb begin
        req_clamped = clamp_track(req_track);
        // A mount seen now or still queued keeps busy high so the host never sees a stale track.
        idle_busy   = (track == 6'd0) || !mounted || pending || img_mounted;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            track      <= 6'd0;
            busy       <= 1'b1;
            sd_lba     <= 32'd0;
            sd_blk_cnt <= 5'd0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            cnt        <= '0;
            target     <= 6'd0;
            req_q      <= 6'd0;
            mounted    <= 1'b0;
            dirty      <= 1'b0;
            pending    <= 1'b0;
            flush      <= 1'b0;
            mtr_q      <= 1'b0;
        end else begin
            mtr_q <= mtr;
            req_q <= req_track;

            case (state)
                IDLE: begin
                    if (pending) begin
                        track   <= 6'd0;
                        dirty   <= 1'b0;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                    end else if (mounted && req_clamped != track) begin
                        state <= SETTLE;
                        cnt   <= SETTLE_LOAD;
                        busy  <= 1'b1;
                    end else if (mtr_q && !mtr && dirty) begin
                        state <= WB_REQ;
                        flush <= 1'b1;
                        dirty <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        busy <= idle_busy;
                    end
                end

                SETTLE: begin
                    // A new image invalidates both the settle and any dirty data; restart from IDLE.
                    if (pending || img_mounted) begin
                        state <= IDLE;
                    end else if (req_track != req_q) begin
                        cnt <= SETTLE_LOAD;
                    end else if (ce) begin
                        if (cnt == CW'(1)) begin
                            target <= req_clamped;
                            if (req_clamped == track) begin
                                state <= IDLE;
                                busy  <= !mounted;
                            end else if (dirty && track != 6'd0) begin
                                state <= WB_REQ;
                                dirty <= 1'b0;
                            end else begin
                                state <= RD_REQ;
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end

                WB_REQ: begin
                    sd_lba     <= track_lba(track);
                    sd_blk_cnt <= track_blk_cnt(track);
                    sd_wr      <= 1'b1;
                    state      <= WB_ACK;
                end

                WB_ACK: begin
                    if (sd_wr) begin
                        if (sd_ack)
                            sd_wr <= 1'b0;
                    end else if (!sd_ack) begin
                        if (flush) begin
                            state <= IDLE;
                            flush <= 1'b0;
                            busy  <= idle_busy;
                        end else begin
                            state <= RD_REQ;
                        end
                    end
                end

                RD_REQ: begin
                    sd_lba     <= track_lba(target);
                    sd_blk_cnt <= track_blk_cnt(target);
                    sd_rd      <= 1'b1;
                    state      <= RD_ACK;
                end

                RD_ACK: begin
                    if (sd_rd) begin
                        if (sd_ack)
                            sd_rd <= 1'b0;
                    end else if (!sd_ack) begin
                        track <= target;
                        state <= IDLE;
                        busy  <= !mounted || pending || img_mounted;
                    end
                end

                default: state <= IDLE;
            endcase

            // NOTE: these follow the case on purpose; with non-blocking assignments the last
            // write in the block wins, so a buff_we overrides the WB_REQ clear and a mount
            // overrides both.
            if (buff_we && !img_readonly)
                dirty <= 1'b1;
            if (img_mounted) begin
                mounted <= img_size_ok;
                pending <= 1'b1;
                dirty   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_c1541_track_loader.sv
// Directed bench for c1541_track_loader: expected SD transfers are queued as stimulus is driven
// and a host model pops and compares them as requests appear, then acknowledges them.
module tb_c1541_track_loader;

    localparam int N = 8;

    typedef struct {
        logic        wr;
        logic [31:0] lba;
        logic [4:0]  blk;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b1;
    logic [5:0]  req_track = 6'd0;
    logic        mtr = 1'b1;
    logic        buff_we = 1'b0;
    logic        img_mounted = 1'b0;
    logic        img_readonly = 1'b0;
    logic        img_size_ok = 1'b0;
    logic        sd_ack = 1'b0;
    logic [5:0]  track;
    logic        busy;
    logic [31:0] sd_lba;
    logic [4:0]  sd_blk_cnt;
    logic        sd_rd;
    logic        sd_wr;

    xfer_t exp_q[$];
    int passed = 0;
    int total = 0;
    int cyc = 0;
    int rd_count = 0;
    int wr_count = 0;
    int rise_cyc = 0;

    c1541_track_loader #(.SETTLE_CYCLES(N)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ce           (ce),
        .req_track    (req_track),
        .mtr          (mtr),
        .buff_we      (buff_we),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size_ok  (img_size_ok),
        .track        (track),
        .busy         (busy),
        .sd_lba       (sd_lba),
        .sd_blk_cnt   (sd_blk_cnt),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_xfer(input logic wr, input logic [31:0] lba, input logic [4:0] blk);
        xfer_t e;
        e.wr  = wr;
        e.lba = lba;
        e.blk = blk;
        exp_q.push_back(e);
    endtask

    task automatic pulse_mount(input logic ok);
        img_size_ok = ok;
        img_mounted = 1'b1;
        step();
        img_mounted = 1'b0;
    endtask

    task automatic pulse_we();
        buff_we = 1'b1;
        step();
        buff_we = 1'b0;
    endtask

    task automatic wait_track(input string tag, input logic [5:0] t);
        int n;
        n = 0;
        while (track !== t && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(track), 32'(t));
    endtask

    task automatic wait_quiet(input string tag);
        int n;
        n = 0;
        repeat (3) step();
        while ((sd_rd || sd_wr || sd_ack || busy || exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_track", 32'(track), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_lba", sd_lba, 32'd0);
        check("rst_blk", 32'(sd_blk_cnt), 32'd0);
        check("rst_rd", 32'(sd_rd), 32'd0);
        check("rst_wr", 32'(sd_wr), 32'd0);
    endtask

    // Host model: compares each new request against the scoreboard, then acknowledges it.
    initial begin : host
        logic        prev;
        logic [31:0] lba0;
        xfer_t       e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if ((sd_rd || sd_wr) && !prev) begin
                rise_cyc = cyc;
                lba0     = sd_lba;
                if (sd_wr) wr_count++;
                else       rd_count++;
                check("rd_wr_exclusive", 32'(sd_rd & sd_wr), 32'd0);
                check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("xfer_dir_wr", 32'(sd_wr), 32'(e.wr));
                    check("xfer_lba", sd_lba, e.lba);
                    check("xfer_blk_cnt", 32'(sd_blk_cnt), 32'(e.blk));
                end
                repeat (3) @(posedge clk);
                #1;
                check("lba_stable", sd_lba, lba0);
                sd_ack = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("req_drop", 32'(sd_rd | sd_wr), 32'd0);
                repeat (2) @(posedge clk);
                #1;
                sd_ack = 1'b0;
                prev = 1'b0;
            end else begin
                prev = sd_rd | sd_wr;
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not complete within cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t0;
        int n;
        int rd0;
        int wr0;

        // Reset state and an unmounted idle period.
        repeat (3) step();
        check_reset_values();
        reset_n = 1'b1;
        repeat (4) step();
        check("busy_unmounted", 32'(busy), 32'd1);

        // Mount and first load of track 18.
        req_track = 6'd18;
        expect_xfer(1'b0, 32'd357, 5'd18);
        pulse_mount(1'b1);
        wait_track("load_18", 6'd18);
        check("busy_after_18", 32'(busy), 32'd0);

        // Track 1 with settle latency measurement.
        step();
        req_track = 6'd1;
        t0 = cyc;
        expect_xfer(1'b0, 32'd0, 5'd20);
        wait_track("load_1", 6'd1);
        check("settle_latency", 32'(rise_cyc - t0), 32'(N + 2));

        // Last standard track.
        expect_xfer(1'b0, 32'd666, 5'd16);
        req_track = 6'd35;
        wait_track("load_35", 6'd35);

        // Clamping: 0 reads as 1, 40 reads as the top track of the build.
        expect_xfer(1'b0, 32'd0, 5'd20);
        req_track = 6'd0;
        wait_track("clamp_0", 6'd1);
`ifdef C1541_TRACK40_EN
        expect_xfer(1'b0, 32'd751, 5'd16);
        req_track = 6'd40;
        wait_track("load_40", 6'd40);
`else
        expect_xfer(1'b0, 32'd666, 5'd16);
        req_track = 6'd40;
        wait_track("clamp_40", 6'd35);
`endif

        // Dirty buffer is written back before the next read.
        expect_xfer(1'b0, 32'd357, 5'd18);
        req_track = 6'd18;
        wait_track("reload_18", 6'd18);
        step();
        pulse_we();
        wr0 = wr_count;
        expect_xfer(1'b1, 32'd357, 5'd18);
        expect_xfer(1'b0, 32'd376, 5'd18);
        req_track = 6'd19;
        wait_track("load_19", 6'd19);
        check("writeback_count", 32'(wr_count - wr0), 32'd1);

        // Read-only image: writes do not mark the buffer dirty.
        img_readonly = 1'b1;
        step();
        pulse_we();
        wr0 = wr_count;
        expect_xfer(1'b0, 32'd395, 5'd18);
        req_track = 6'd20;
        wait_track("load_20_ro", 6'd20);
        check("readonly_no_wr", 32'(wr_count - wr0), 32'd0);
        img_readonly = 1'b0;

        // Head wobbling faster than the settle time yields exactly one read.
        expect_xfer(1'b0, 32'd452, 5'd18);
        req_track = 6'd23;
        wait_track("load_23", 6'd23);
        step();
        rd0 = rd_count;
        for (int i = 0; i < 6; i++) begin
            req_track = (i % 2 == 0) ? 6'd20 : 6'd21;
            repeat (N / 2) step();
        end
        expect_xfer(1'b0, 32'd395, 5'd18);
        req_track = 6'd20;
        wait_track("settled_20", 6'd20);
        wait_quiet("wobble_quiet");
        check("wobble_one_read", 32'(rd_count - rd0), 32'd1);

        // Motor off with dirty data flushes the current track only.
        pulse_we();
        wr0 = wr_count;
        expect_xfer(1'b1, 32'd395, 5'd18);
        mtr = 1'b0;
        wait_quiet("flush_quiet");
        check("flush_wr", 32'(wr_count - wr0), 32'd1);
        check("flush_track", 32'(track), 32'd20);
        mtr = 1'b1;
        step();

        // Mount during a read: read completes, track invalidated, same track reloaded clean.
        expect_xfer(1'b0, 32'd471, 5'd18);
        expect_xfer(1'b0, 32'd471, 5'd18);
        req_track = 6'd24;
        n = 0;
        while (!sd_rd && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rd_seen_24", 32'(sd_rd), 32'd1);
        step();
        pulse_we();
        wr0 = wr_count;
        pulse_mount(1'b1);
        wait_track("mid_mount_read", 6'd24);
        @(negedge clk);
        check("mount_track0", 32'(track), 32'd0);
        check("mount_busy", 32'(busy), 32'd1);
        wait_track("reload_24", 6'd24);
        wait_quiet("mount_quiet");
        check("mount_no_wr", 32'(wr_count - wr0), 32'd0);

        // Reset while the host is acknowledging.
        expect_xfer(1'b0, 32'd490, 5'd17);
        req_track = 6'd25;
        n = 0;
        while (!sd_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ack_seen_25", 32'(sd_ack), 32'd1);
        reset_n = 1'b0;
        repeat (4) step();
        check_reset_values();
        reset_n = 1'b1;
        step();
        expect_xfer(1'b0, 32'd490, 5'd17);
        pulse_mount(1'b1);
        wait_track("reload_25", 6'd25);
        wait_quiet("final_quiet");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
